fir_pipe_param: RTL and testbench

//  Parametrised, signed, transposed-form pipelined FIR for sample-stream datapaths; successor to the fixed 5-tap unsigned FIR.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_pipe_param_if.sv | 40 ++++
 rtl/fir_tap_slice.sv | 56 +++++
 rtl/fir_pipe_param.sv | 131 +++++++++++++
 tb/tb_fir_pipe_param.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared helpers for the FIR datapath.
//   clog2      - ceiling log2 for sizing address fields and accumulator growth
//   acc_width  - accumulator width: sample + coefficient + tap-count growth bits
//   sample_t / coef_t - signed sample and coefficient types at the default widths,
//                       for DSP blocks that use those widths
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
    return data_w + coef_w + clog2(n_taps);
  endfunction

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;

endpackage

// File: rtl/fir_pipe_param_if.sv
// fir_pipe_param_if: sample stream, control and coefficient bus of the FIR.
//   in_valid/sample_in        : input sample stream (master -> slave)
//   flush                     : clear pipeline and tap state (master -> slave)
//   coef_we/coef_addr/coef_wdata : shadow coefficient write (master -> slave)
//   coef_commit               : copy shadow bank to active bank (master -> slave)
//   out_valid/fir_out         : filtered output stream (slave -> master)
// Handshake: valid-only streams, no ready. A sample is taken on every rising
// edge where in_valid=1; fir_out is meaningful on every cycle where
// out_valid=1 and the consumer must accept it then (no backpressure).
interface fir_pipe_param_if #(
  parameter int N_TAPS = 5,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  import fir_pkg::*;

  localparam int ADDR_W = clog2(N_TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] sample_in;
  logic                     flush;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_commit;
  logic                     out_valid;
  logic [OUT_W-1:0]         fir_out;

  modport master (
    output in_valid, sample_in, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    input  out_valid, fir_out
  );

  modport slave (
    input  in_valid, sample_in, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    output out_valid, fir_out
  );

endinterface

// File: rtl/fir_tap_slice.sv
// fir_tap_slice: one tap of the transposed FIR chain.
//   p = x * coef registered every cycle (x only changes on valid samples).
//   s = p + s_in registered only when en (a valid product is present), so
//   idle cycles do not shift the chain.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   flush         : clears p and s at the next edge
//   en            : advance the chain this cycle
//   x, coef       : signed sample and coefficient
//   s_in          : partial sum from the next-higher tap (0 for the last tap)
//   s_out         : this tap's partial sum
module fir_tap_slice
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [ACC_W-1:0]  s_in,
  output logic signed [ACC_W-1:0]  s_out
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] p_q, p_d;
  logic signed [ACC_W-1:0]  s_q, s_d;

  always_comb begin
    p_d = PROD_W'(x) * PROD_W'(coef);
    s_d = s_q;
    if (en) s_d = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q} + s_in;
    if (flush) begin
      p_d = '0;
      s_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q <= '0;
      s_q <= '0;
    end else begin
      p_q <= p_d;
      s_q <= s_d;
    end
  end

  assign s_out = s_q;

endmodule

// File: rtl/fir_pipe_param.sv
// fir_pipe_param: parametrised signed transposed-form pipelined FIR.
// Stage 1 registers the valid sample, stage 2 forms all products, stage 3
// advances the transposed adder chain; output is 3 edges after the sample.
// Coefficients live in a shadow bank (written by coef_we) and an active bank
// (loaded from shadow on coef_commit); both reset to COEF_INIT.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fir_pipe_param_if slave (sample in, flush, coefficient bus, output)
// Build option: define FIR_ROUND_SAT_EN to round half-up and saturate the
// scaled output; otherwise the output is a truncating, wrapping bit slice.
module fir_pipe_param
  import fir_pkg::*;
#(
  parameter int N_TAPS    = 5,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0,
  parameter logic [N_TAPS*COEF_W-1:0] COEF_INIT = 40'h03_07_14_07_03
) (
  input logic              clock,
  input logic              reset,
  fir_pipe_param_if.slave  bus
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);
  localparam int EXT_W = ACC_W + OUT_SHIFT + OUT_W;

  logic signed [COEF_W-1:0] shadow_q [N_TAPS];
  logic signed [COEF_W-1:0] shadow_d [N_TAPS];
  logic signed [COEF_W-1:0] active_q [N_TAPS];
  logic signed [COEF_W-1:0] active_d [N_TAPS];

  logic signed [DATA_W-1:0] x_q, x_d;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  logic signed [ACC_W-1:0] s_chain [N_TAPS];

  // Commit reads shadow_q, so a same-cycle write only reaches the shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (bus.coef_commit) active_d = shadow_q;
    if (bus.coef_we && (int'(bus.coef_addr) < N_TAPS))
      shadow_d[bus.coef_addr] = bus.coef_wdata;
  end

  // Flush wins over a same-cycle valid sample.
  always_comb begin
    x_d  = x_q;
    v1_d = bus.in_valid;
    if (bus.in_valid) x_d = bus.sample_in;
    v2_d = v1_q;
    v3_d = v2_q;
    if (bus.flush) begin
      x_d  = '0;
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
        active_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
      x_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      x_q      <= x_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
    end
  end

  // Tap 0's partial sum is the filter output y.
  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    if (k == N_TAPS - 1) begin : g_last
      fir_tap_slice #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap (
        .clock (clock), .reset (reset), .flush (bus.flush), .en (v2_q),
        .x (x_q), .coef (active_q[k]), .s_in ('0), .s_out (s_chain[k])
      );
    end else begin : g_mid
      fir_tap_slice #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap (
        .clock (clock), .reset (reset), .flush (bus.flush), .en (v2_q),
        .x (x_q), .coef (active_q[k]), .s_in (s_chain[k+1]), .s_out (s_chain[k])
      );
    end
  end

  // y widened so the shifted slice never runs past its sign bit.
  logic signed [EXT_W-1:0] y_ext;
  assign y_ext = {{(OUT_SHIFT+OUT_W){s_chain[0][ACC_W-1]}}, s_chain[0]};

  assign bus.out_valid = v3_q;

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] y_rnd, y_sh;
  logic [OUT_W-1:0]        out_sat;

  if (OUT_SHIFT > 0) begin : g_rnd
    assign y_rnd = y_ext + (EXT_W'(1) << (OUT_SHIFT - 1));
  end else begin : g_nornd
    assign y_rnd = y_ext;
  end

  assign y_sh = y_rnd >>> OUT_SHIFT;

  always_comb begin
    out_sat = y_sh[OUT_W-1:0];
    if (y_sh > OUT_MAX) out_sat = OUT_MAX[OUT_W-1:0];
    if (y_sh < OUT_MIN) out_sat = OUT_MIN[OUT_W-1:0];
  end

  assign bus.fir_out = out_sat;
`else
  assign bus.fir_out = OUT_W'(y_ext >>> OUT_SHIFT);
`endif

endmodule

// File: tb/tb_fir_pipe_param.sv
// tb_fir_pipe_param: randomized and directed stimulus for fir_pipe_param with
// a reference model computed directly from the FIR definition: each valid
// sample is stored with the coefficient bank in force when its products
// form, and each output is the sum over the last N_TAPS samples of
// sample * that sample's coefficient for its tap distance.
// Two DUTs share the stimulus: a default build and a narrow-output build
// (OUT_W=8, OUT_SHIFT=2) for the scaling/overflow behaviour.
module tb_fir_pipe_param;
  import fir_pkg::*;

  localparam int N_TAPS     = 5;
  localparam int DATA_W     = 8;
  localparam int COEF_W     = 8;
  localparam int OUT_W      = 16;
  localparam int OUT_SHIFT  = 0;
  localparam int OUT2_W     = 8;
  localparam int OUT2_SHIFT = 2;
  localparam int ADDR_W     = clog2(N_TAPS);
  localparam logic [N_TAPS*COEF_W-1:0] COEF_INIT = 40'h03_07_14_07_03;

  typedef int coefs_t [N_TAPS];

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   started = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  fir_pipe_param_if #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W))  bus ();
  fir_pipe_param_if #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT2_W)) bus2 ();

  assign bus2.in_valid    = bus.in_valid;
  assign bus2.sample_in   = bus.sample_in;
  assign bus2.flush       = bus.flush;
  assign bus2.coef_we     = bus.coef_we;
  assign bus2.coef_addr   = bus.coef_addr;
  assign bus2.coef_wdata  = bus.coef_wdata;
  assign bus2.coef_commit = bus.coef_commit;

  fir_pipe_param #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
                   .OUT_SHIFT(OUT_SHIFT), .COEF_INIT(COEF_INIT))
    dut (.clock(clock), .reset(reset), .bus(bus));

  fir_pipe_param #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT2_W),
                   .OUT_SHIFT(OUT2_SHIFT), .COEF_INIT(COEF_INIT))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));

  // ---------------- reference model + scoreboard ----------------
  coefs_t init_c = '{3, 7, 20, 7, 3};
  coefs_t m_shadow, m_active;
  int     hist_x [$];
  coefs_t hist_c [$];

  logic [OUT_W-1:0]  exp_q  [$];
  int                due_q  [$];
  logic [OUT2_W-1:0] exp2_q [$];
  int                due2_q [$];

  int checks = 0;
  int failures = 0;

  function automatic longint scale(input longint y, input int sh, input int ow);
    longint r;
`ifdef FIR_ROUND_SAT_EN
    longint hi, lo;
    r = y;
    if (sh > 0) r = (y + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = y >>> sh;
`endif
    return r;
  endfunction

  // Drop expectations for samples still inside the pipeline when it is cleared.
  task automatic prune();
    while (due_q.size() > 0 && due_q[$] > cyc) begin
      void'(due_q.pop_back());
      void'(exp_q.pop_back());
    end
    while (due2_q.size() > 0 && due2_q[$] > cyc) begin
      void'(due2_q.pop_back());
      void'(exp2_q.pop_back());
    end
  endtask

  task automatic model_step(input bit rst, input bit iv, input int smp, input bit fl,
                            input bit we, input int addr, input int wdata, input bit cm);
    longint y;
    int n;
    if (rst) begin
      m_shadow = init_c;
      m_active = init_c;
      hist_x.delete();
      hist_c.delete();
      prune();
    end else begin
      if (cm) m_active = m_shadow;
      if (we && addr < N_TAPS) m_shadow[addr] = wdata;
      if (fl) begin
        hist_x.delete();
        hist_c.delete();
        prune();
      end else if (iv) begin
        hist_x.push_back(smp);
        hist_c.push_back(m_active);
        if (hist_x.size() > N_TAPS) begin
          void'(hist_x.pop_front());
          void'(hist_c.pop_front());
        end
        n = hist_x.size();
        y = 0;
        for (int k = 0; k < N_TAPS && k < n; k++)
          y += longint'(hist_c[n-1-k][k]) * longint'(hist_x[n-1-k]);
        exp_q.push_back(OUT_W'(scale(y, OUT_SHIFT, OUT_W)));
        due_q.push_back(cyc + 3);
        exp2_q.push_back(OUT2_W'(scale(y, OUT2_SHIFT, OUT2_W)));
        due2_q.push_back(cyc + 3);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit iv, input int smp, input bit fl,
                       input bit we, input int addr, input int wdata, input bit cm);
    @(posedge clock);
    #1;
    reset           = rst;
    bus.in_valid    = iv;
    bus.sample_in   = DATA_W'(smp);
    bus.flush       = fl;
    bus.coef_we     = we;
    bus.coef_addr   = ADDR_W'(addr);
    bus.coef_wdata  = COEF_W'(wdata);
    bus.coef_commit = cm;
    model_step(rst, iv, smp, fl, we, addr, wdata, cm);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic samp(input int s);
    drive(0, 1, s, 0, 0, 0, 0, 0);
  endtask

  task automatic impulse();
    samp(1);
    repeat (5) samp(0);
    idle(4);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (started) begin
      if (bus.out_valid !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_main_unexpected cyc=%0d got=%0d expected no output", cyc, $signed(bus.fir_out));
        end else begin
          logic [OUT_W-1:0] e;
          int d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (bus.out_valid !== 1'b1 || bus.fir_out !== e || d != cyc) begin
            failures++;
            $display("FAIL out_main cyc=%0d got=%0d (valid=%b) expected=%0d at cyc=%0d",
                     cyc, $signed(bus.fir_out), bus.out_valid, $signed(e), d);
          end
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL out_main_missing cyc=%0d got no output expected=%0d", cyc, $signed(exp_q[0]));
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      if (bus2.out_valid !== 1'b0) begin
        checks++;
        if (exp2_q.size() == 0) begin
          failures++;
          $display("FAIL out_narrow_unexpected cyc=%0d got=%0d expected no output", cyc, $signed(bus2.fir_out));
        end else begin
          logic [OUT2_W-1:0] e;
          int d;
          e = exp2_q.pop_front();
          d = due2_q.pop_front();
          if (bus2.out_valid !== 1'b1 || bus2.fir_out !== e || d != cyc) begin
            failures++;
            $display("FAIL out_narrow cyc=%0d got=%0d (valid=%b) expected=%0d at cyc=%0d",
                     cyc, $signed(bus2.fir_out), bus2.out_valid, $signed(e), d);
          end
        end
      end else if (due2_q.size() > 0 && due2_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL out_narrow_missing cyc=%0d got no output expected=%0d", cyc, $signed(exp2_q[0]));
        void'(due2_q.pop_front());
        void'(exp2_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 0; bus.sample_in = '0; bus.flush = 0; bus.coef_we = 0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.coef_commit = 0;
    m_shadow = init_c;
    m_active = init_c;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clock);
    checks += 4;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_main got=%b expected=0", bus.out_valid); end
    if (bus.fir_out !== '0) begin failures++; $display("FAIL reset_out_main got=%0h expected=0", bus.fir_out); end
    if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_narrow got=%b expected=0", bus2.out_valid); end
    if (bus2.fir_out !== '0) begin failures++; $display("FAIL reset_out_narrow got=%0h expected=0", bus2.fir_out); end
    started = 1'b1;

    // impulse with default coefficients
    impulse();

    // positive then negative step
    repeat (8) samp(10);
    repeat (8) samp(-10);
    idle(4);

    // gapped impulse
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    samp(1);
    idle(2);
    repeat (5) begin samp(0); idle(2); end
    idle(4);

    // shadow writes {1,0,0,0,0}, commit on the last write keeps old tap 4
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    for (int a = 1; a < 4; a++) drive(0, 0, 0, 0, 1, a, 0, 0);
    drive(0, 0, 0, 0, 1, 4, 0, 1);
    impulse();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    impulse();
    // out-of-range writes are ignored
    drive(0, 0, 0, 0, 1, 5, 77, 0);
    drive(0, 0, 0, 0, 1, 7, -3, 1);
    impulse();

    // flush together with a valid sample mid-stream
    samp(5); samp(6); samp(7);
    drive(0, 1, 99, 1, 0, 0, 0, 0);
    impulse();

    // reset after a swap restores the default bank
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    impulse();

    // overflow / scaling
    repeat (8) samp(127);
    repeat (8) samp(-128);
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit rst, iv, fl, we, cm;
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 7) == 0);
      cm  = ($urandom_range(0, 19) == 0);
      drive(rst, iv, int'($urandom_range(0, 255)) - 128, fl, we,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128, cm);
    end

    idle(8);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending main=%0d narrow=%0d expected 0", exp_q.size(), exp2_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
